// File: rtl/sub_max.sv
// sub_max: softmax stage that follows the max-finder. It latches the frame
// maximum (scale) on the upstream done edge, streams the source memory,
// writes saturate(data - scale) to the destination memory and then hands off
// to the next stage with the ready/done handshake.
module sub_max #(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int DATA_SIZE = 1024,
  parameter int RD_LAT    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          upstream_done,
  input  logic [DW-1:0] scale_in,
  output logic          sub_max_ready,
  input  logic [DW-1:0] data_in,
  output logic [AW-1:0] rd_addr,
  output logic [DW-1:0] wr_data,
  output logic [AW-1:0] wr_addr,
  output logic          wr_ena,
  input  logic          downstream_ready,
  output logic          sub_max_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR  = AW'(DATA_SIZE - 1);
  localparam logic [2:0]    DRAIN_LAST = 3'(RD_LAT);

  state_t        state_r;
  state_t        state_s;
  logic          upstream_done_q;
  logic          start_s;
  logic [DW-1:0] scale_r;
  logic [AW-1:0] cnt_r;
  logic [2:0]    drain_cnt_r;
  logic          ready_r;
  logic          done_r;

  // Read-side delay line: stage RD_LAT-1 lines up with the returning data_in.
  logic [RD_LAT-1:0] vld_sr;
  logic [AW-1:0]     addr_sr [RD_LAT];
  logic              wr_ena_r;
  logic [AW-1:0]     wr_addr_r;
  logic [DW-1:0]     wr_data_r;

  // Saturating signed subtract computed one bit wider than the operands;
  // the two top bits disagree exactly when the result leaves the DW range.
  function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic signed [DW:0] diff;
    diff = $signed({a[DW-1], a}) - $signed({b[DW-1], b});
    if (diff[DW] != diff[DW-1]) begin
      if (diff[DW]) begin
        sat_sub = {1'b1, {(DW-1){1'b0}}};
      end else begin
        sat_sub = {1'b0, {(DW-1){1'b1}}};
      end
    end else begin
      sat_sub = diff[DW-1:0];
    end
  endfunction

  assign start_s = upstream_done & ~upstream_done_q;

  // Next-state decode for the frame sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s && ready_r) state_s = RUN;
        else                    state_s = IDLE;
      end
      RUN: begin
        if (cnt_r == LAST_ADDR) state_s = DRAIN;
        else                    state_s = RUN;
      end
      DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) state_s = DONE;
        else                           state_s = DRAIN;
      end
      DONE: begin
        if (downstream_ready) state_s = IDLE;
        else                  state_s = HOLD;
      end
      HOLD: begin
        if (downstream_ready) state_s = IDLE;
        else                  state_s = HOLD;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, scale latch, address/drain counters and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      upstream_done_q <= 1'b0;
      scale_r         <= '0;
      cnt_r           <= '0;
      drain_cnt_r     <= 3'd0;
      ready_r         <= 1'b1;
      done_r          <= 1'b0;
    end else begin
      state_r         <= state_s;
      upstream_done_q <= upstream_done;
      ready_r         <= (state_s == IDLE);
      done_r          <= (state_s == DONE);
      if (state_r == IDLE && state_s == RUN) begin
        scale_r <= scale_in;
      end
      // cnt parks on the last address until the frame is handed off
      if (state_r == RUN && state_s == RUN) begin
        cnt_r <= cnt_r + AW'(1);
      end else if (state_s == IDLE) begin
        cnt_r <= '0;
      end
      if (state_r == DRAIN) begin
        drain_cnt_r <= drain_cnt_r + 3'd1;
      end else begin
        drain_cnt_r <= 3'd0;
      end
    end
  end

  // Valid/address delay line and the registered saturating write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr    <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_sr[i] <= '0;
      wr_ena_r  <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
    end else begin
      vld_sr[0]  <= (state_r == RUN);
      addr_sr[0] <= cnt_r;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        addr_sr[i] <= addr_sr[i-1];
      end
      wr_ena_r <= vld_sr[RD_LAT-1];
      if (vld_sr[RD_LAT-1]) begin
        wr_addr_r <= addr_sr[RD_LAT-1];
        wr_data_r <= sat_sub(data_in, scale_r);
      end
    end
  end

  assign rd_addr       = cnt_r;
  assign wr_ena        = wr_ena_r;
  assign wr_addr       = wr_addr_r;
  assign wr_data       = wr_data_r;
  assign sub_max_ready = ready_r;
  assign sub_max_done  = done_r;

endmodule

// File: doc/sub_max.md
Name: sub_max

Overview:
- Softmax stage directly downstream of the max-finder.
- Captures the one-cycle max value (scale) that the max-finder presents with its done pulse.
- Streams the intermediate memory the max-finder wrote, subtracts scale from every element with saturation, and writes the results to the next intermediate memory.
- Uses the same ready/done handshake as the rest of the CNN pipeline, so it chains with the exp stage that follows.

Parameters:
- AW, 12, address width of the read and write memory ports.
- DW, 32, data width; elements are signed two's-complement fixed point.
- DATA_SIZE, 1024, number of elements per frame (must be <= 2^AW).
- RD_LAT, 1, read latency of the source memory in cycles (1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- upstream_done  in  1  done signal from the max-finder; a frame starts on its rising edge.
- scale_in  in  DW  max value; valid only in the cycle upstream_done rises.
- sub_max_ready  out  1  high when able to accept a new frame.
- data_in  in  DW  source memory read data, valid RD_LAT cycles after rd_addr.
- rd_addr  out  AW  source memory read address.
- wr_data  out  DW  saturated (data_in - scale).
- wr_addr  out  AW  destination memory write address.
- wr_ena  out  1  destination memory write strobe.
- downstream_ready  in  1  the next stage can accept a new frame.
- sub_max_done  out  1  one-cycle pulse after the last write of a frame.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - state=IDLE, sub_max_ready=1, all other outputs 0, scale register 0, counters 0.
  - Any in-flight reads are discarded; no write occurs after reset deasserts.
- Start detection:
  - start = upstream_done & ~upstream_done_q, where upstream_done_q is a registered copy that resets to 0.
  - A start is accepted only in IDLE with sub_max_ready=1.
  - In that same cycle scale_in is latched, sub_max_ready falls to 0 on the next edge, and state goes to RUN.
  - Starts seen in any other state are ignored; scale is not relatched.
- States:
  - IDLE: rd_addr=0, wr_ena=0.
  - RUN: rd_addr=cnt; cnt counts 0..DATA_SIZE-1, one address per cycle, no stalls. After issuing DATA_SIZE-1, go to DRAIN.
  - DRAIN: wait RD_LAT+1 cycles for the pipeline to empty, then go to DONE.
  - DONE: sub_max_done=1 for exactly one cycle, then go to HOLD.
  - HOLD: when downstream_ready=1, set sub_max_ready=1 and go to IDLE.
  - If downstream_ready is already 1 in the DONE cycle, go straight to IDLE (ready=1 the following cycle), skipping HOLD.
- Pipeline:
  - Address k is issued in cycle t.
  - data_in for k is sampled at t+RD_LAT.
  - The registered subtract result appears at t+RD_LAT+1 with wr_ena=1 and wr_addr=k.
  - wr_ena is high for exactly DATA_SIZE consecutive cycles per frame, with addresses strictly ascending 0..DATA_SIZE-1.
  - The valid/address delay line is a shift register of depth RD_LAT+1.
- Arithmetic:
  - Compute diff = data_in - scale at DW+1 bits, signed.
  - If diff > 2^(DW-1)-1, wr_data = 2^(DW-1)-1.
  - If diff < -2^(DW-1), wr_data = -2^(DW-1).
  - Otherwise wr_data = diff[DW-1:0].
  - wr_data holds its last value when wr_ena=0.
- Boundaries:
  - DATA_SIZE=1: one write, then the done pulse RD_LAT+2 cycles after the RUN cycle.
  - upstream_done held high across frames triggers only once; it must go low and rise again.
  - cnt never wraps: it stops at DATA_SIZE-1.
- Latency: from the start cycle, the first write is at +RD_LAT+2 and sub_max_done at +DATA_SIZE+RD_LAT+2.

Test Plan:
- Basic frame: DATA_SIZE=4, RD_LAT=1, scale_in=100, memory {100,50,0,-20} -> writes {0,-50,-100,-120} at addrs 0..3 on consecutive cycles; done pulse 1 cycle after the last write; ready stays 0 until downstream_ready=1.
- Saturation: DW=8, scale=100, data=-100 -> wr_data=-128; scale=-100, data=100 -> wr_data=127.
- Handshake: downstream_ready=0 for 10 cycles after done -> ready stays 0 and a second upstream_done rise in that window is ignored (no writes); with downstream_ready=1, a subsequent rise starts a frame.
- Scale latch: scale_in valid only on the start cycle, then driven to 0xDEADBEEF -> all outputs use the latched value.
- Reset mid-frame: assert rst at cnt=2 -> wr_ena=0 immediately, ready=1, no done pulse; a following start runs a clean full frame.
- RD_LAT=3, DATA_SIZE=1, data=7, scale=7 -> single write of 0 at addr 0, 5 cycles after start; done on the next cycle.
